traffic_phase_sequencer: RTL

Finite-state sequencer for the traffic-light controller. It owns the phase timer, steps a main/side intersection through green, yellow and red phases, and serves a pedestrian request with a dedicated walk phase. It replaces ad-hoc count decoding with an explicit FSM and configurable phase durations. Its count output remains available to downstream display logic.

---
 rtl/traffic_phase_sequencer_if.sv | 34 +++
 rtl/traffic_phase_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer_if
// Groups the control inputs and the light/status outputs of the traffic phase
// sequencer into one bundle.
//   tick_en, side_req, ped_req : driven by the controller side (master)
//   main_lt, side_lt           : {red, yellow, green} lamp drives
//   walk, ped_ack, ped_pending : pedestrian lamp, walk-start pulse, latched request
//   state, count               : debug state code and phase timer value
// The sequencer itself connects through the slave modport.
// -----------------------------------------------------------------------------
interface traffic_phase_sequencer_if #(
    parameter int CW = 8
);
    logic          tick_en;
    logic          side_req;
    logic          ped_req;
    logic [2:0]    main_lt;
    logic [2:0]    side_lt;
    logic          walk;
    logic          ped_ack;
    logic          ped_pending;
    logic [2:0]    state;
    logic [CW-1:0] count;

    modport master (
        output tick_en, side_req, ped_req,
        input  main_lt, side_lt, walk, ped_ack, ped_pending, state, count
    );

    modport slave (
        input  tick_en, side_req, ped_req,
        output main_lt, side_lt, walk, ped_ack, ped_pending, state, count
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// Steps a main/side intersection through green, yellow and red phases and
// serves pedestrian requests with a dedicated walk phase. Owns the phase timer.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : slave side of traffic_phase_sequencer_if (tick strobe, side and
//            pedestrian requests in; lamps, walk, ped_ack, ped_pending, state
//            and count out). All outputs come straight from flops.
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int CW     = 8,
    parameter int MG_T   = 20,
    parameter int MY_T   = 10,
    parameter int SG_T   = 40,
    parameter int SY_T   = 10,
    parameter int WALK_T = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    traffic_phase_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_MG   = 3'd0,
        ST_MY   = 3'd1,
        ST_SG   = 3'd2,
        ST_SY   = 3'd3,
        ST_WALK = 3'd4
    } state_t;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ped_pending_q, ped_pending_d;
    logic          ped_ack_q, ped_ack_d;
    logic          walk_q, walk_d;
    logic [2:0]    main_lt_q, main_lt_d;
    logic [2:0]    side_lt_q, side_lt_d;

    // Per-state phase parameters: last timer value and successor state.
    logic [CW-1:0] dur_m1;
    state_t        succ;
    logic          legal;
    logic          at_last;
    logic          leave;
    logic          enter_walk;

    always_comb begin
        dur_m1 = CW'(MG_T - 1);
        succ   = ST_MG;
        legal  = 1'b1;
        case (state_q)
            ST_MG: begin
                dur_m1 = CW'(MG_T - 1);
                succ   = ST_MY;
            end
            ST_MY: begin
                dur_m1 = CW'(MY_T - 1);
                succ   = ST_SG;
            end
            ST_SG: begin
                dur_m1 = CW'(SG_T - 1);
                succ   = ST_SY;
            end
            ST_SY: begin
                dur_m1 = CW'(SY_T - 1);
                // Uses the registered request only: a button press in the
                // same cycle as the SY phase end waits for the next round.
                succ   = ped_pending_q ? ST_WALK : ST_MG;
            end
            ST_WALK: begin
                dur_m1 = CW'(WALK_T - 1);
                succ   = ST_MG;
            end
            default: legal = 1'b0;
        endcase
    end

    assign at_last = (count_q == dur_m1);

    always_comb begin
        // Main green: once the timer sits at its last value it stays there
        // until a request shows up, and then leaves without waiting for a
        // tick. With a continuous tick this is exactly the normal phase end.
        if (state_q == ST_MG) begin
            leave = at_last && (bus.side_req || ped_pending_q);
        end else begin
            leave = bus.tick_en && at_last;
        end

        state_d = state_q;
        count_d = count_q;
        if (!legal) begin
            state_d = ST_MG;
            count_d = '0;
        end else if (leave) begin
            state_d = succ;
            count_d = '0;
        end else if (bus.tick_en && !at_last) begin
            // Saturating: the timer never passes the phase's last value.
            count_d = count_q + CW'(1);
        end

        enter_walk = legal && leave && (succ == ST_WALK);

        // The walk-entry clear beats a simultaneous press; presses during
        // WALK are dropped.
        if (enter_walk) begin
            ped_pending_d = 1'b0;
        end else if (state_q == ST_WALK) begin
            ped_pending_d = ped_pending_q;
        end else begin
            ped_pending_d = ped_pending_q | bus.ped_req;
        end

        ped_ack_d = enter_walk;
        walk_d    = (state_d == ST_WALK);

        // Lamps are decoded from the next state so that the registered lamp
        // outputs always match the state register in the same cycle.
        main_lt_d = LT_RED;
        side_lt_d = LT_RED;
        case (state_d)
            ST_MG:   main_lt_d = LT_GREEN;
            ST_MY:   main_lt_d = LT_YELLOW;
            ST_SG:   side_lt_d = LT_GREEN;
            ST_SY:   side_lt_d = LT_YELLOW;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_MG;
            count_q       <= '0;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
            walk_q        <= 1'b0;
            main_lt_q     <= LT_GREEN;
            side_lt_q     <= LT_RED;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
            walk_q        <= walk_d;
            main_lt_q     <= main_lt_d;
            side_lt_q     <= side_lt_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.count       = count_q;
    assign bus.ped_pending = ped_pending_q;
    assign bus.ped_ack     = ped_ack_q;
    assign bus.walk        = walk_q;
    assign bus.main_lt     = main_lt_q;
    assign bus.side_lt     = side_lt_q;

endmodule
